out_port_fifo: RTL and testbench
================================

# out_port_fifo

Output buffer between the multicycle CPU's `out` register and the downstream display/serial consumer. Every CPU output-write strobe pushes a 16-bit word into a small FIFO. The consumer drains the FIFO through a valid/ready handshake. The block raises `stall` toward the control unit when it cannot accept a word, and keeps sticky overflow and drop statistics for debug.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of two, ≥ 2.
- `WIDTH`, default 16: data width; matches the CPU word.
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `wr_en` in 1: CPU output-write strobe, one cycle per write.
- `wr_data` in `WIDTH`: word the CPU writes to `out`.
- `stall` out 1: tells the control unit to hold its output-write state; equals `full`.
- `full` out 1: registered; high when `count == DEPTH`.
- `out_valid` out 1: registered; high when `count != 0`.
- `out_data` out `WIDTH`: head entry when `out_valid` is high; `0` when the FIFO is empty.
- `out_ready` in 1: the consumer accepts the head word.
- `count` out `$clog2(DEPTH)+1`: occupancy, 0..`DEPTH`.
- `overflow` out 1: sticky; set on the first dropped write; cleared only by `reset`.
- `drop_count` out 8: number of dropped writes; saturates at 255.

## Operation
- Storage is `DEPTH` × `WIDTH` registers, with `wr_ptr` and `rd_ptr` each `$clog2(DEPTH)` bits wide; both pointers wrap modulo `DEPTH`.
- Pop condition: `pop = out_valid & out_ready`. A pop advances `rd_ptr`.
- Push condition: `push = wr_en & (~full | pop)`. A push writes `mem[wr_ptr] <= wr_data` and advances `wr_ptr`.
- Drop condition: `drop = wr_en & full & ~pop`. A drop sets `overflow` and increments `drop_count` unless it is already 255. Storage and pointers are not changed.
- Count update: `count` increases by 1 on push only, decreases by 1 on pop only, and is unchanged when push and pop happen together or when neither happens.
- `full` and `out_valid` are registered and derived from the next value of `count`. There is no combinational path from `out_ready` or `wr_en` to `full`, `stall`, or `out_valid`.
- `out_data` is `mem[rd_ptr]` (first-word fall-through) while `out_valid` is high.
- Push while empty: the word cannot be popped in the same cycle, because `out_valid` is still 0.
- Push while full with a simultaneous pop: the write is accepted. `count` stays at `DEPTH` and `full` stays high.
- `out_ready` while empty has no effect.
- Reset state, including mid-operation: `wr_ptr = 0`, `rd_ptr = 0`, `count = 0`, `full = 0`, `stall = 0`, `out_valid = 0`, `out_data = 0`, `overflow = 0`, `drop_count = 0`. In-flight contents are discarded. Storage contents need not be cleared.
- Control structure: the block has no FSM beyond the counter. The two status flags `out_valid` and `full` together form an empty / partial / full state:
  - EMPTY → PARTIAL on a push with no pop.
  - PARTIAL → FULL when `count` reaches `DEPTH`.
  - FULL → PARTIAL on a pop with no push.
  - PARTIAL → EMPTY when `count` reaches 0.

## Timing
- Write latency: a push at edge N gives `out_valid = 1` and the word on `out_data` after edge N, so it can be consumed at edge N+1.
- Words emerge in write order, one word per cycle maximum.
- Sustained throughput is 1 word/cycle when push and pop happen together.
- `stall` asserts in the cycle after the push that fills the FIFO. The control unit must sample `stall` before issuing the next `wr_en`.
- A `wr_en` issued while `stall` is high and no pop occurs is dropped, not queued.
- `overflow` and `drop_count` update at the same edge as the dropped write.
- Reset is asynchronous: all outputs reach their reset values without waiting for a clock edge. Release is synchronous to `clock`.

## Test plan
- **Reset then single write.** Assert `reset`, release it, then pulse `wr_en` with `wr_data = 16'h13B0` and hold `out_ready = 0`.
  - Required: one cycle later `out_valid = 1`, `out_data = 16'h13B0`, `count = 1`.
  - Then raise `out_ready` for one cycle. Required: `count = 0`, `out_valid = 0`, `out_data = 0`.
- **Fill to full.** With `out_ready = 0`, push 8 words `16'h0001` … `16'h0008`.
  - Required: `full = stall = 1` and `count = 8`.
  - A 9th write of `16'hBEEF` is dropped: `overflow = 1`, `drop_count = 1`, and draining yields `16'h0001` … `16'h0008` in order with no `16'hBEEF`.
- **Full with simultaneous push/pop.** With the FIFO holding `16'h0001` … `16'h0008`, push `16'h0009` and set `out_ready = 1` in the same cycle.
  - Required: `16'h0001` is popped, `16'h0009` is accepted, `count` stays 8, `full` stays 1, `drop_count` is unchanged.
- **Streaming and pointer wrap-around.** Hold `out_ready = 1` and push 20 consecutive words `16'h0100` … `16'h0113`.
  - Required: outputs appear in order with 1-cycle latency, `count ≤ 1` throughout, and no drops.
- **Saturation.** While full with `out_ready = 0`, issue 300 writes.
  - Required: `drop_count = 255`, `overflow = 1`, and the contents are unchanged.
- **Reset mid-operation.** With `count = 5`, assert `reset` asynchronously between clock edges.
  - Required: `count = 0`, `out_valid = 0`, `full = 0`, `overflow = 0`, `drop_count = 0` immediately.
  - After release, the first write `16'hA5A5` is the first word out.

Source files
------------

// File: rtl/out_port_fifo_if.sv
// Handshake bundle between the CPU output-write path, the output FIFO and the
// downstream consumer. The FIFO uses the slave modport; the environment uses master.
interface out_port_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
);
  // Handshake: a word is written when wr_en is high and either full is low or a
  // pop happens in the same cycle. It is read when out_valid & out_ready are both
  // high at a rising clock edge. wr_en while full with no pop drops the word.
  logic                       wr_en;
  logic [WIDTH-1:0]           wr_data;
  logic                       stall;
  logic                       full;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic [7:0]                 drop_count;

  modport master (
    output wr_en, wr_data, out_ready,
    input  stall, full, out_valid, out_data, count, overflow, drop_count
  );

  modport slave (
    input  wr_en, wr_data, out_ready,
    output stall, full, out_valid, out_data, count, overflow, drop_count
  );
endinterface

// File: rtl/out_port_fifo.sv
// First-word-fall-through output FIFO with registered status flags, stall back to
// the control unit, and sticky overflow / saturating drop statistics.
module out_port_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic            clock,
  input  logic            reset,
  out_port_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             full_q;
  logic             valid_q;
  logic             overflow_q;
  logic [7:0]       drop_q;
  logic             push;
  logic             pop;
  logic             drop;

  // A pop frees a slot in the same cycle, so a write while full is still accepted.
  assign pop  = valid_q & bus.out_ready;
  assign push = bus.wr_en & (~full_q | pop);
  assign drop = bus.wr_en & full_q & ~pop;

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_next;
      full_q  <= (count_next == CW'(DEPTH));
      valid_q <= (count_next != '0);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Storage needs no reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full       = full_q;
  assign bus.stall      = full_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = valid_q ? mem[rd_ptr] : '0;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo: reset, single write, fill/drop, full push+pop,
// streaming with pointer wrap, drop saturation and asynchronous reset mid-operation.
module tb_out_port_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic clock;
  logic reset;
  int   checks;
  int   passed;
  logic [WIDTH-1:0] exp_q[$];

  out_port_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  out_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_words(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = base + WIDTH'(i);
      exp_q.push_back(base + WIDTH'(i));
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    checks++; if (bus.count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else passed++;
    checks++; if (bus.full !== 1'b0 || bus.stall !== 1'b0) $display("FAIL reset_full got full=%b stall=%b exp=0/0", bus.full, bus.stall); else passed++;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000) $display("FAIL reset_out got valid=%b data=%h exp=0/0000", bus.out_valid, bus.out_data); else passed++;
    checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) $display("FAIL reset_stats got ovf=%b drops=%0d exp=0/0", bus.overflow, bus.drop_count); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    bus.wr_en = 1'b1; bus.wr_data = 16'h13B0; bus.out_ready = 1'b0;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h13B0 || bus.count !== 4'd1)
      $display("FAIL single_write got valid=%b data=%h count=%0d exp=1/13b0/1", bus.out_valid, bus.out_data, bus.count); else passed++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.count !== 4'd0)
      $display("FAIL single_pop got valid=%b data=%h count=%0d exp=0/0000/0", bus.out_valid, bus.out_data, bus.count); else passed++;
  endtask

  task automatic test_fill_and_drop();
    logic [WIDTH-1:0] exp;
    push_words(7, 16'h0001);
    checks++; if (bus.full !== 1'b0 || bus.count !== 4'd7) $display("FAIL fill_seven got full=%b count=%0d exp=0/7", bus.full, bus.count); else passed++;
    push_words(1, 16'h0008);
    checks++; if (bus.full !== 1'b1 || bus.stall !== 1'b1 || bus.count !== 4'd8)
      $display("FAIL fill_full got full=%b stall=%b count=%0d exp=1/1/8", bus.full, bus.stall, bus.count); else passed++;
    bus.wr_en = 1'b1; bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1 || bus.count !== 4'd8)
      $display("FAIL drop_one got ovf=%b drops=%0d count=%0d exp=1/1/8", bus.overflow, bus.drop_count, bus.count); else passed++;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp) $display("FAIL fill_drain got valid=%b data=%h exp=1/%h", bus.out_valid, bus.out_data, exp); else passed++;
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) $display("FAIL fill_empty got count=%0d valid=%b exp=0/0", bus.count, bus.out_valid); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [WIDTH-1:0] exp;
    push_words(8, 16'h0001);
    checks++; if (bus.out_data !== 16'h0001) $display("FAIL pp_head got=%h exp=0001", bus.out_data); else passed++;
    bus.wr_en = 1'b1; bus.wr_data = 16'h0009; bus.out_ready = 1'b1;
    exp_q.push_back(16'h0009);
    void'(exp_q.pop_front());
    tick();
    bus.wr_en = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.drop_count !== 8'd1 || bus.out_data !== 16'h0002)
      $display("FAIL pp_full got count=%0d full=%b drops=%0d head=%h exp=8/1/1/0002", bus.count, bus.full, bus.drop_count, bus.out_data); else passed++;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++; if (bus.out_data !== exp) $display("FAIL pp_drain got=%h exp=%h", bus.out_data, exp); else passed++;
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp;
    int bad_count;
    int bad_data;
    bad_count = 0; bad_data = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'h0100 + 16'(i);
      tick();
      exp = 16'h0100 + 16'(i);
      if (bus.count > 4'd1) bad_count++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) bad_data++;
    end
    bus.wr_en = 1'b0;
    checks++; if (bad_count != 0) $display("FAIL stream_count got=%0d cycles with count>1 exp=0", bad_count); else passed++;
    checks++; if (bad_data != 0) $display("FAIL stream_order got=%0d bad words exp=0", bad_data); else passed++;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.drop_count !== 8'd1) $display("FAIL stream_end got count=%0d drops=%0d exp=0/1", bus.count, bus.drop_count); else passed++;
  endtask

  task automatic test_saturation();
    logic [WIDTH-1:0] exp;
    push_words(8, 16'h0020);
    for (int i = 0; i < 300; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'($urandom_range(0, 16'hFFFF));
      tick();
    end
    bus.wr_en = 1'b0;
    checks++; if (bus.drop_count !== 8'd255 || bus.overflow !== 1'b1 || bus.count !== 4'd8)
      $display("FAIL saturate got drops=%0d ovf=%b count=%0d exp=255/1/8", bus.drop_count, bus.overflow, bus.count); else passed++;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++; if (bus.out_data !== exp) $display("FAIL sat_drain got=%h exp=%h", bus.out_data, exp); else passed++;
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_words(5, 16'h0040);
    exp_q.delete();
    checks++; if (bus.count !== 4'd5) $display("FAIL mid_pre got count=%0d exp=5", bus.count); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0 || bus.full !== 1'b0 || bus.out_data !== 16'h0000)
      $display("FAIL mid_async got count=%0d valid=%b full=%b data=%h exp=0/0/0/0000", bus.count, bus.out_valid, bus.full, bus.out_data); else passed++;
    checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0)
      $display("FAIL mid_stats got ovf=%b drops=%0d exp=0/0", bus.overflow, bus.drop_count); else passed++;
    tick();
    reset = 1'b0;
    tick();
    bus.wr_en = 1'b1; bus.wr_data = 16'hA5A5;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA5A5 || bus.count !== 4'd1)
      $display("FAIL mid_first got valid=%b data=%h count=%0d exp=1/a5a5/1", bus.out_valid, bus.out_data, bus.count); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    test_reset();
    test_single_write();
    test_fill_and_drop();
    test_full_push_pop();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
